seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector: watches a one-bit serial input and flags every occurrence of a runtime-loadable pattern of 1 to MAX_LEN bits, with selectable overlapping or non-overlapping detection and a saturating match counter. It is the general replacement for the fixed 4-bit Mealy sequence detectors in the serial front-end. Reset defaults make it detect 1011, non-overlapping.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_sat_cnt.sv | 22 ++
 rtl/seq_detect_param.sv | 100 ++++++++++
 tb/tb_seq_detect_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_MAX_LEN   = 8;
  localparam int         DEF_CNT_W     = 8;
  localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1011;
  localparam int         DEF_LEN_C     = 4;
  localparam logic       DEF_OVERLAP_C = 1'b0;

  // Width needed to hold a length in 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int clamp_len(input int l, input int max_len);
    return (l > max_len) ? max_len : l;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern/length, overlap mode and
// saturating match counter. y is Mealy (same cycle as completing bit).
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int                 DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = DEF_OVERLAP_C
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        x,
  input  logic                        x_valid,
  input  logic                        cfg_load,
  input  logic [MAX_LEN-1:0]          cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        cnt_clr,
  output logic                        y,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        armed
);

  localparam int LW = len_w(MAX_LEN);

  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               reach;
  logic               match;
  logic [LW-1:0]      len_nxt;
  logic [LW-1:0]      fill_nxt;
  logic               armed_nxt;

  always_comb begin
    cand   = {hist[MAX_LEN-2:0], x};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
    accept = x_valid && !cfg_load;
    // fill >= len-1, evaluated one bit wider so len=0 cannot underflow
    reach  = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
    match  = accept && (len != '0) && reach && (((cand ^ pat) & mask) == '0);
    y      = match;

    len_nxt  = cfg_load ? LW'(clamp_len(int'(cfg_len), MAX_LEN)) : len;
    fill_nxt = fill;
    if (cfg_load) begin
      fill_nxt = '0;
    end else if (accept) begin
      if (match && !ovl) begin
        fill_nxt = '0;
      end else if (fill != LW'(MAX_LEN)) begin
        fill_nxt = fill + LW'(1);
      end
    end
    armed_nxt = (len_nxt != '0) &&
                (({1'b0, fill_nxt} + (LW+1)'(1)) >= {1'b0, len_nxt});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat   <= DEF_PATTERN;
      len   <= LW'(clamp_len(DEF_LEN, MAX_LEN));
      ovl   <= DEF_OVERLAP;
      hist  <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      if (cfg_load) begin
        pat  <= cfg_pattern;
        ovl  <= cfg_overlap;
        hist <= '0;
      end else if (accept) begin
        hist <= cand;
      end
      len   <= len_nxt;
      fill  <= fill_nxt;
      armed <= armed_nxt;
    end
  end

  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       y;
  logic [1:0] match_cnt;
  logic       armed;

  int checks = 0;
  int passed = 0;

  seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .match_cnt   (match_cnt),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  // Present one bit, sample y mid-cycle, then return 1 time unit after the edge.
  task automatic step(input logic b, input logic v, output logic yo);
    x = b;
    x_valid = v;
    @(negedge clk);
    yo = y;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cfg_load = 1'b0;
    cnt_clr = 1'b0;
    x_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    logic yo;
    do_reset();
    checks++;
    if (armed !== 1'b0) $display("FAIL reset_armed got %b exp 0", armed); else passed++;
    checks++;
    if (match_cnt !== 2'd0) $display("FAIL reset_cnt got %0d exp 0", match_cnt); else passed++;
    step(1'b1, 1'b1, yo);
    checks++;
    if (yo !== 1'b0) $display("FAIL reset_first_bit_y got %b exp 0", yo); else passed++;
  endtask

  task automatic test_default_stream();
    logic [6:0] bits;
    logic [6:0] exp_y;
    logic yo;
    bits  = 7'b1011011;
    exp_y = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1, yo);
      checks++;
      if (yo !== exp_y[6-i]) $display("FAIL default_y bit%0d got %b exp %b", i+1, yo, exp_y[6-i]);
      else passed++;
      if (i == 2) begin
        checks++;
        if (armed !== 1'b1) $display("FAIL default_armed_after3 got %b exp 1", armed); else passed++;
      end
      if (i == 3) begin
        checks++;
        if (armed !== 1'b0) $display("FAIL default_armed_after_match got %b exp 0", armed); else passed++;
      end
    end
    checks++;
    if (match_cnt !== 2'd1) $display("FAIL default_cnt got %0d exp 1", match_cnt); else passed++;
  endtask

  task automatic test_overlap();
    logic [4:0] bits;
    logic [4:0] exp_ov;
    logic [4:0] exp_no;
    logic yo;
    bits   = 5'b10101;
    exp_ov = 5'b00101;
    exp_no = 5'b00100;
    do_reset();
    load(8'b101, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(bits[4-i], 1'b1, yo);
      checks++;
      if (yo !== exp_ov[4-i]) $display("FAIL ovl1_y bit%0d got %b exp %b", i+1, yo, exp_ov[4-i]);
      else passed++;
    end
    checks++;
    if (match_cnt !== 2'd2) $display("FAIL ovl1_cnt got %0d exp 2", match_cnt); else passed++;
    load(8'b101, 4'd3, 1'b0);
    checks++;
    if (match_cnt !== 2'd2) $display("FAIL load_keeps_cnt got %0d exp 2", match_cnt); else passed++;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(bits[4-i], 1'b1, yo);
      checks++;
      if (yo !== exp_no[4-i]) $display("FAIL ovl0_y bit%0d got %b exp %b", i+1, yo, exp_no[4-i]);
      else passed++;
    end
    checks++;
    if (match_cnt !== 2'd1) $display("FAIL ovl0_cnt got %0d exp 1", match_cnt); else passed++;
  endtask

  task automatic test_gap();
    logic yo;
    do_reset();
    step(1'b1, 1'b1, yo);
    step(1'b0, 1'b1, yo);
    step(1'b1, 1'b1, yo);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, yo);
      checks++;
      if (yo !== 1'b0) $display("FAIL gap_invalid_y cycle%0d got %b exp 0", i, yo); else passed++;
    end
    step(1'b1, 1'b1, yo);
    checks++;
    if (yo !== 1'b1) $display("FAIL gap_final_y got %b exp 1", yo); else passed++;
  endtask

  task automatic test_saturation();
    logic yo;
    do_reset();
    load(8'h01, 4'd1, 1'b0);
    checks++;
    if (armed !== 1'b1) $display("FAIL len1_armed got %b exp 1", armed); else passed++;
    step(1'b0, 1'b1, yo);
    checks++;
    if (yo !== 1'b0) $display("FAIL len1_zero_y got %b exp 0", yo); else passed++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, yo);
      checks++;
      if (yo !== 1'b1) $display("FAIL len1_y bit%0d got %b exp 1", i, yo); else passed++;
    end
    checks++;
    if (match_cnt !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", match_cnt); else passed++;
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, yo);
    cnt_clr = 1'b0;
    checks++;
    if (yo !== 1'b1) $display("FAIL clr_match_y got %b exp 1", yo); else passed++;
    checks++;
    if (match_cnt !== 2'd0) $display("FAIL clr_beats_inc got %0d exp 0", match_cnt); else passed++;
  endtask

  task automatic test_load_abort();
    logic [3:0] bits;
    logic [3:0] exp_y;
    logic yo;
    bits  = 4'b1011;
    exp_y = 4'b0001;
    do_reset();
    step(1'b1, 1'b1, yo);
    step(1'b0, 1'b1, yo);
    step(1'b1, 1'b1, yo);
    cfg_pattern = 8'b0000_1011;
    cfg_len = 4'd4;
    cfg_overlap = 1'b0;
    cfg_load = 1'b1;
    step(1'b1, 1'b1, yo);
    cfg_load = 1'b0;
    checks++;
    if (yo !== 1'b0) $display("FAIL load_abort_y got %b exp 0", yo); else passed++;
    checks++;
    if (armed !== 1'b0) $display("FAIL load_abort_armed got %b exp 0", armed); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, yo);
      checks++;
      if (yo !== exp_y[3-i]) $display("FAIL after_load_y bit%0d got %b exp %b", i+1, yo, exp_y[3-i]);
      else passed++;
    end
    step(1'b1, 1'b1, yo);
    step(1'b0, 1'b1, yo);
    step(1'b1, 1'b1, yo);
    rst = 1'b0;
    x = 1'b1;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    x_valid = 1'b0;
    checks++;
    if (armed !== 1'b0) $display("FAIL rst_abort_armed got %b exp 0", armed); else passed++;
    checks++;
    if (match_cnt !== 2'd0) $display("FAIL rst_abort_cnt got %0d exp 0", match_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, yo);
      checks++;
      if (yo !== exp_y[3-i]) $display("FAIL after_rst_y bit%0d got %b exp %b", i+1, yo, exp_y[3-i]);
      else passed++;
    end
  endtask

  task automatic test_len_limits();
    logic [4:0] noise;
    logic [7:0] p8;
    logic yo;
    noise = 5'b11101;
    p8    = 8'b1100_1010;
    do_reset();
    load(8'h01, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(noise[4-i], 1'b1, yo);
      checks++;
      if (yo !== 1'b0) $display("FAIL len0_y bit%0d got %b exp 0", i+1, yo); else passed++;
    end
    checks++;
    if (armed !== 1'b0) $display("FAIL len0_armed got %b exp 0", armed); else passed++;
    load(p8, 4'd15, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++;
        if (armed !== 1'b1) $display("FAIL len8_armed got %b exp 1", armed); else passed++;
      end
      step(p8[7-i], 1'b1, yo);
      checks++;
      if (yo !== (i == 7)) $display("FAIL len8_y bit%0d got %b exp %b", i+1, yo, (i == 7));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_overlap();
    test_gap();
    test_saturation();
    test_load_abort();
    test_len_limits();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
